// File: rtl/icache_types_pkg.sv
// Shared types for the 2-way, 8-set, 32B-line icache control path.
// Optional hit/miss counters are enabled with ICACHE_PERF_EN.
package icache_types_pkg;

   localparam int NUM_WAYS   = 2;
   localparam int NUM_SETS   = 8;
   localparam int LINE_BYTES = 32;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      FETCH,
      INSTALL,
      SETTLE
   } icache_state_t;

   typedef logic way_t;

   function automatic logic [NUM_WAYS-1:0] way_onehot(input way_t w);
      return w ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way pick: first invalid way, otherwise the LRU way.
// Purely combinational.
module icache_victim_sel
   import icache_types_pkg::*;
(
   input  logic [NUM_WAYS-1:0] valid_out,
   input  logic                lru_output,
   output way_t                victim
);

   always_comb begin
      victim = way_t'(lru_output);
      if (!valid_out[0]) begin
         victim = 1'b0;
      end else if (!valid_out[1]) begin
         victim = 1'b1;
      end
   end

endmodule

// File: rtl/icache_control.sv
// Icache control FSM: hit check, victim pick, line fetch, install, settle.
// Define ICACHE_PERF_EN to add saturating hit_count/miss_count ports.
module icache_control
   import icache_types_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int PERF_CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_read,
   output logic                mem_resp,
   input  logic [NUM_WAYS-1:0] hit_datapath,
   input  logic                lru_output,
   input  logic [NUM_WAYS-1:0] valid_out,
   output logic                pmem_read,
   input  logic                pmem_resp,
   output logic                load_lru,
   output logic                set_lru,
   output logic [NUM_WAYS-1:0] load_valid,
   output logic [NUM_WAYS-1:0] load_tag,
   output logic                mem_enable_sel,
   output logic                data_way
`ifdef ICACHE_PERF_EN
   ,
   output logic [PERF_CNT_W-1:0] hit_count,
   output logic [PERF_CNT_W-1:0] miss_count
`endif
);

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1 || PERF_CNT_W < 1) begin : g_param_chk
      $error("icache_control: bad parameter value");
   end

   icache_state_t    state_q, state_d;
   way_t             victim_q, victim_d;
   way_t             victim_pick;
   way_t             hit_way;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic             any_hit;
   logic             check_hit;
   logic             check_miss;

   icache_victim_sel u_victim_sel (
      .valid_out  (valid_out),
      .lru_output (lru_output),
      .victim     (victim_pick)
   );

   // Both hit bits set cannot happen legally; way0 wins.
   assign any_hit    = |hit_datapath;
   assign hit_way    = hit_datapath[0] ? 1'b0 : 1'b1;
   assign check_hit  = (state_q == CHECK) && mem_read && any_hit;
   assign check_miss = (state_q == CHECK) && mem_read && !any_hit;

   always_comb begin
      state_d  = state_q;
      victim_d = victim_q;
      settle_d = settle_q;
      unique case (state_q)
         IDLE: begin
            if (mem_read) state_d = CHECK;
         end
         CHECK: begin
            if (!mem_read || any_hit) begin
               state_d = IDLE;
            end else begin
               victim_d = victim_pick;
               state_d  = FETCH;
            end
         end
         FETCH: begin
            if (pmem_resp) state_d = INSTALL;
         end
         INSTALL: begin
            settle_d = '0;
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = CHECK;
            end else begin
               settle_d = settle_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_resp       = 1'b0;
      pmem_read      = 1'b0;
      load_lru       = 1'b0;
      set_lru        = 1'b0;
      load_valid     = '0;
      load_tag       = '0;
      mem_enable_sel = 1'b0;
      data_way       = 1'b0;
      unique case (state_q)
         CHECK: begin
            if (check_hit) begin
               mem_resp = 1'b1;
               load_lru = 1'b1;
               set_lru  = ~hit_way;
            end
         end
         FETCH: begin
            pmem_read = 1'b1;
         end
         INSTALL: begin
            mem_enable_sel = 1'b1;
            data_way       = victim_q;
            load_tag       = way_onehot(victim_q);
            load_valid     = way_onehot(victim_q);
            load_lru       = 1'b1;
            set_lru        = ~victim_q;
         end
         default: ;
      endcase
   end

`ifdef ICACHE_PERF_EN
   logic [PERF_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [PERF_CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (check_hit && !(&hit_cnt_q)) begin
         hit_cnt_d = hit_cnt_q + PERF_CNT_W'(1);
      end
      if (check_miss && !(&miss_cnt_q)) begin
         miss_cnt_d = miss_cnt_q + PERF_CNT_W'(1);
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         victim_q   <= 1'b0;
         settle_q   <= '0;
`ifdef ICACHE_PERF_EN
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         victim_q   <= victim_d;
         settle_q   <= settle_d;
`ifdef ICACHE_PERF_EN
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_icache_control.sv
// Self-checking bench for icache_control: per-cycle expected output traces
// are planned from request-level rules and compared against the DUT.
module tb_icache_control;

   localparam int SC = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mem_read = 1'b0;
   logic       pmem_resp = 1'b0;
   logic       lru_output = 1'b0;
   logic [1:0] hit_datapath = 2'b00;
   logic [1:0] valid_out = 2'b00;
   logic       mem_resp, pmem_read, load_lru, set_lru;
   logic [1:0] load_valid, load_tag;
   logic       mem_enable_sel, data_way;
`ifdef ICACHE_PERF_EN
   logic [31:0] hit_count, miss_count;
`endif

   always #5 clk = ~clk;

   icache_control #(.SETTLE_CYCLES(SC), .PERF_CNT_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_read       (mem_read),
      .mem_resp       (mem_resp),
      .hit_datapath   (hit_datapath),
      .lru_output     (lru_output),
      .valid_out      (valid_out),
      .pmem_read      (pmem_read),
      .pmem_resp      (pmem_resp),
      .load_lru       (load_lru),
      .set_lru        (set_lru),
      .load_valid     (load_valid),
      .load_tag       (load_tag),
      .mem_enable_sel (mem_enable_sel),
      .data_way       (data_way)
`ifdef ICACHE_PERF_EN
      ,
      .hit_count      (hit_count),
      .miss_count     (miss_count)
`endif
   );

   typedef struct packed {
      logic       mr;
      logic [1:0] hit;
      logic [1:0] vld;
      logic       lru;
      logic       pr;
   } stim_t;

   stim_t      sq[$];
   logic [9:0] eq[$];
   int         errors = 0;
   int         checks = 0;
   int         exp_hit = 0;
   int         exp_miss = 0;

   function automatic logic [9:0] obs_vec();
      return {mem_resp, pmem_read, load_lru, set_lru, load_valid,
              load_tag, mem_enable_sel, data_way};
   endfunction

   function automatic stim_t mk(logic mr, logic [1:0] hit, logic [1:0] vld,
                                logic lru, logic pr);
      return {mr, hit, vld, lru, pr};
   endfunction

   // A hit on way w makes the other way least recently used.
   function automatic logic [9:0] resp_vec(logic w);
      return {1'b1, 1'b0, 1'b1, ~w, 6'b0};
   endfunction

   function automatic logic [9:0] fetch_vec();
      return 10'b01_0000_0000;
   endfunction

   function automatic logic [9:0] install_vec(logic v);
      logic [1:0] oh;
      oh = 2'b01 << v;
      return {1'b0, 1'b0, 1'b1, ~v, oh, oh, 1'b1, v};
   endfunction

   // Fill the first empty way, otherwise replace the LRU way.
   function automatic logic ref_victim(logic [1:0] vld, logic lru);
      for (int w = 0; w < 2; w++) begin
         if (!vld[w]) return w[0];
      end
      return lru;
   endfunction

   task automatic push(input stim_t s, input logic [9:0] e);
      sq.push_back(s);
      eq.push_back(e);
   endtask

   task automatic step(input stim_t s, output logic [9:0] o);
      mem_read     = s.mr;
      hit_datapath = s.hit;
      valid_out    = s.vld;
      lru_output   = s.lru;
      pmem_resp    = s.pr;
      @(negedge clk);
      o = obs_vec();
      @(posedge clk);
      #1;
   endtask

   // One CPU request as a cycle-by-cycle stimulus/expectation trace.
   task automatic plan(input bit hit_first, input logic [1:0] hitv,
                       input logic [1:0] vld, input logic lru,
                       input int flat, input int drop, input bit tail);
      logic v;
      logic mr;
      logic hw;
      push(mk(1'b1, 2'b00, vld, lru, 1'b0), 10'b0);
      if (hit_first) begin
         hw = hitv[0] ? 1'b0 : 1'b1;
         push(mk(1'b1, hitv, vld, lru, 1'b0), resp_vec(hw));
         exp_hit++;
      end else begin
         v  = ref_victim(vld, lru);
         mr = 1'b1;
         push(mk(1'b1, 2'b00, vld, lru, 1'b0), 10'b0);
         exp_miss++;
         for (int i = 0; i <= flat; i++) begin
            if (i == drop) mr = 1'b0;
            push(mk(mr, 2'b00, vld, lru, i == flat), fetch_vec());
         end
         push(mk(mr, 2'b00, vld, lru, 1'b0), install_vec(v));
         for (int i = 0; i < SC; i++) begin
            push(mk(mr, 2'b00, vld, lru, 1'b0), 10'b0);
         end
         if (mr) begin
            push(mk(1'b1, 2'b01 << v, 2'b11, lru, 1'b0), resp_vec(v));
            exp_hit++;
         end else begin
            push(mk(1'b0, 2'b01 << v, 2'b11, lru, 1'b0), 10'b0);
         end
      end
      if (tail) push(mk(1'b0, 2'b00, vld, lru, 1'b0), 10'b0);
   endtask

   task automatic test_reset();
      logic [9:0] o;
      rst = 1'b0;
      mem_read = 1'b1;
      pmem_resp = 1'b1;
      #3;
      o = obs_vec();
      checks++;
      if (o !== 10'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=%b", o, 10'b0);
      end
      @(posedge clk);
      #1;
      o = obs_vec();
      checks++;
      if (o !== 10'b0) begin
         errors++;
         $display("FAIL reset_held got=%b exp=%b", o, 10'b0);
      end
`ifdef ICACHE_PERF_EN
      checks++;
      if (hit_count !== 0 || miss_count !== 0) begin
         errors++;
         $display("FAIL reset_counters got=%0d/%0d exp=0/0",
                  hit_count, miss_count);
      end
`endif
      mem_read = 1'b0;
      pmem_resp = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_hit = 0;
      exp_miss = 0;
   endtask

   task automatic test_cold_miss();
      stim_t s;
      logic [9:0] e, o;
      plan(1'b0, 2'b00, 2'b00, 1'b0, 5, -1, 1'b1);
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL cold_miss cyc%0d got=%b exp=%b", c, o, e);
         end
      end
   endtask

   task automatic test_hit_way1();
      stim_t s;
      logic [9:0] e, o;
      plan(1'b1, 2'b10, 2'b11, 1'b1, 0, -1, 1'b1);
      plan(1'b1, 2'b11, 2'b11, 1'b0, 0, -1, 1'b1);
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL hit_way1 cyc%0d got=%b exp=%b", c, o, e);
         end
      end
   endtask

   task automatic test_full_set();
      stim_t s;
      logic [9:0] e, o;
      plan(1'b0, 2'b00, 2'b11, 1'b1, 2, -1, 1'b1);
      plan(1'b0, 2'b00, 2'b11, 1'b0, 1, -1, 1'b1);
      plan(1'b0, 2'b00, 2'b01, 1'b0, 0, -1, 1'b1);
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL full_set cyc%0d got=%b exp=%b", c, o, e);
         end
      end
   endtask

   task automatic test_drop_fetch();
      stim_t s;
      logic [9:0] e, o;
      plan(1'b0, 2'b00, 2'b10, 1'b1, 4, 2, 1'b1);
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL drop_fetch cyc%0d got=%b exp=%b", c, o, e);
         end
      end
   endtask

   task automatic test_reset_fetch();
      stim_t s;
      logic [9:0] e, o;
      push(mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0), 10'b0);
      push(mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0), 10'b0);
      push(mk(1'b1, 2'b00, 2'b11, 1'b0, 1'b0), fetch_vec());
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rst_fetch_pre cyc%0d got=%b exp=%b", c, o, e);
         end
      end
      #2;
      checks++;
      if (pmem_read !== 1'b1) begin
         errors++;
         $display("FAIL rst_fetch_busy got=%b exp=1", pmem_read);
      end
      rst = 1'b0;
      #1;
      o = obs_vec();
      checks++;
      if (o !== 10'b0) begin
         errors++;
         $display("FAIL rst_fetch_async got=%b exp=%b", o, 10'b0);
      end
      exp_hit = 0;
      exp_miss = 0;
      pmem_resp = 1'b1;
      @(negedge clk);
      o = obs_vec();
      checks++;
      if (o !== 10'b0) begin
         errors++;
         $display("FAIL rst_fetch_held got=%b exp=%b", o, 10'b0);
      end
      pmem_resp = 1'b0;
      mem_read = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      push(mk(1'b0, 2'b00, 2'b11, 1'b0, 1'b0), 10'b0);
      push(mk(1'b0, 2'b00, 2'b11, 1'b0, 1'b1), 10'b0);
      plan(1'b0, 2'b00, 2'b11, 1'b0, 1, -1, 1'b1);
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rst_fetch_post cyc%0d got=%b exp=%b", c, o, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s;
      logic [9:0] e, o;
      plan(1'b1, 2'b01, 2'b11, 1'b0, 0, -1, 1'b0);
      plan(1'b0, 2'b00, 2'b11, 1'b0, 0, -1, 1'b0);
      plan(1'b1, 2'b10, 2'b11, 1'b1, 0, -1, 1'b0);
      plan(1'b0, 2'b00, 2'b10, 1'b1, 3, 0, 1'b1);
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL back_to_back cyc%0d got=%b exp=%b", c, o, e);
         end
      end
   endtask

   task automatic test_random();
      stim_t s;
      logic [9:0] e, o;
      int flat;
      int drop;
      for (int r = 0; r < 40; r++) begin
         flat = int'($urandom_range(0, 4));
         drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, flat)) : -1;
         plan(1'($urandom_range(0, 1)), 2'($urandom_range(1, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              flat, drop, 1'($urandom_range(0, 1)));
      end
      push(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0), 10'b0);
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL random cyc%0d got=%b exp=%b", c, o, e);
         end
      end
   endtask

`ifdef ICACHE_PERF_EN
   task automatic test_perf();
      stim_t s;
      logic [9:0] e, o;
      test_reset();
      plan(1'b1, 2'b01, 2'b11, 1'b0, 0, -1, 1'b1);
      plan(1'b0, 2'b00, 2'b00, 1'b0, 2, -1, 1'b1);
      plan(1'b1, 2'b10, 2'b11, 1'b0, 0, -1, 1'b1);
      plan(1'b0, 2'b00, 2'b11, 1'b1, 1, -1, 1'b1);
      plan(1'b1, 2'b11, 2'b11, 1'b0, 0, -1, 1'b1);
      for (int c = 0; sq.size() > 0; c++) begin
         s = sq.pop_front();
         e = eq.pop_front();
         step(s, o);
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL perf_trace cyc%0d got=%b exp=%b", c, o, e);
         end
      end
      checks++;
      if (hit_count !== 32'(exp_hit)) begin
         errors++;
         $display("FAIL perf_hits got=%0d exp=%0d", hit_count, exp_hit);
      end
      checks++;
      if (miss_count !== 32'(exp_miss)) begin
         errors++;
         $display("FAIL perf_misses got=%0d exp=%0d", miss_count, exp_miss);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_cold_miss();
      test_hit_way1();
      test_full_set();
      test_drop_fetch();
      test_reset_fetch();
      test_back_to_back();
      test_random();
`ifdef ICACHE_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
